// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage: PC register, next-PC select, IF/ID
//               pipeline register and a RUN/HALTED fetch controller.
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
    parameter int             LEN       = 32,
    parameter logic [LEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_stall,
    input  logic           i_flush,
    input  logic [1:0]     i_pc_src,
    input  logic [LEN-1:0] i_branch_target,
    input  logic [LEN-1:0] i_jump_target,
    input  logic [LEN-1:0] i_jr_target,
    input  logic [LEN-1:0] i_instr,
    output logic [LEN-1:0] o_pc,
    output logic [LEN-1:0] o_pc_plus4,
    output logic [LEN-1:0] o_instr,
    output logic           o_valid,
    output logic           o_halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [LEN-1:0] C_FOUR = {{(LEN-3){1'b0}}, 3'b100};

    state_t         r_state, w_state_nxt;
    logic [LEN-1:0] r_pc, w_pc_nxt;
    logic [LEN-1:0] r_instr, w_instr_nxt;
    logic [LEN-1:0] r_pc_plus4, w_pc_plus4_nxt;
    logic           r_valid, w_valid_nxt;

    logic [LEN-1:0] w_pc_plus4;
    logic [LEN-1:0] w_target;
    logic [LEN-1:0] w_target_aligned;
    logic           w_redirect;
    logic           w_halt_fetch;

    assign w_pc_plus4       = r_pc + C_FOUR;
    assign w_redirect       = (i_pc_src != 2'b00);
    assign w_target_aligned = {w_target[LEN-1:2], 2'b00};

    // A halt word only counts once it is accepted on the sequential path.
    assign w_halt_fetch = (i_instr == HALT_WORD) && !i_stall && !i_flush && !w_redirect;

    always_comb begin
        w_target = i_branch_target;
        case (i_pc_src)
            2'b01:   w_target = i_branch_target;
            2'b10:   w_target = i_jump_target;
            2'b11:   w_target = i_jr_target;
            default: w_target = i_branch_target;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc_plus4_nxt = r_pc_plus4;
        w_valid_nxt    = r_valid;
        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target_aligned;
                end else if (!i_stall && !w_halt_fetch) begin
                    w_pc_nxt = w_pc_plus4;
                end

                if (i_flush) begin
                    w_instr_nxt    = '0;
                    w_pc_plus4_nxt = '0;
                    w_valid_nxt    = 1'b0;
                end else if (!i_stall) begin
                    w_instr_nxt    = i_instr;
                    w_pc_plus4_nxt = w_pc_plus4;
                    w_valid_nxt    = 1'b1;
                end

                if (w_halt_fetch) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_instr_nxt    = '0;
                w_pc_plus4_nxt = '0;
                w_valid_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus4 <= w_pc_plus4_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;
    assign o_valid    = r_valid;
    assign o_halted   = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed vector bench for fetch_stage.
// Revision    : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall, flush;
    logic [1:0]  pc_src;
    logic [31:0] br_t, jmp_t, jr_t, instr;
    logic [31:0] pc, pc_plus4, instr_q;
    logic        valid, halted;

    int total;
    int bad;

    fetch_stage dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_pc_src       (pc_src),
        .i_branch_target(br_t),
        .i_jump_target  (jmp_t),
        .i_jr_target    (jr_t),
        .i_instr        (instr),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4),
        .o_instr        (instr_q),
        .o_valid        (valid),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] instr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic        e_halt;
    } vec_t;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] JUNK = 32'hDEAD_BEE0;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_in,
                           input logic [31:0] e_pp4, input logic e_v, input logic e_h);
        chk({tag, ".pc"},     pc,              e_pc);
        chk({tag, ".instr"},  instr_q,         e_in);
        chk({tag, ".pc4"},    pc_plus4,        e_pp4);
        chk({tag, ".valid"},  {31'd0, valid},  {31'd0, e_v});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_h});
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic [1:0] src,
                                input logic [31:0] tgt, input logic [31:0] in,
                                input logic [31:0] epc, input logic [31:0] ein,
                                input logic [31:0] epp4, input logic ev, input logic eh);
        vec_t v;
        v.stall = s; v.flush = f; v.src = src; v.tgt = tgt; v.instr = in;
        v.e_pc = epc; v.e_instr = ein; v.e_pp4 = epp4; v.e_valid = ev; v.e_halt = eh;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        stall  = v.stall;
        flush  = v.flush;
        pc_src = v.src;
        instr  = v.instr;
        br_t   = (v.src == 2'b01) ? v.tgt : JUNK;
        jmp_t  = (v.src == 2'b10) ? v.tgt : JUNK ^ 32'h0000_1110;
        jr_t   = (v.src == 2'b11) ? v.tgt : JUNK ^ 32'h0000_2220;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            stall flush src    tgt           instr          e_pc          e_instr       e_pp4        v  h
        vecs[0]  = mk(0, 0, 2'b00, 32'h0,         32'h1111_1111, 32'h4,         32'h1111_1111, 32'h4,   1, 0);
        vecs[1]  = mk(0, 0, 2'b00, 32'h0,         32'h2222_2222, 32'h8,         32'h2222_2222, 32'h8,   1, 0);
        vecs[2]  = mk(1, 0, 2'b00, 32'h0,         32'h3333_3333, 32'h8,         32'h2222_2222, 32'h8,   1, 0);
        vecs[3]  = mk(1, 0, 2'b00, 32'h0,         32'h3333_3333, 32'h8,         32'h2222_2222, 32'h8,   1, 0);
        vecs[4]  = mk(0, 0, 2'b00, 32'h0,         32'h3333_3333, 32'hC,         32'h3333_3333, 32'hC,   1, 0);
        vecs[5]  = mk(0, 0, 2'b00, 32'h0,         32'h4444_4444, 32'h10,        32'h4444_4444, 32'h10,  1, 0);
        // redirect + flush + stall together: redirect wins on PC, flush on IF/ID
        vecs[6]  = mk(1, 1, 2'b01, 32'h103,       32'h5555_5555, 32'h100,       32'h0,         32'h0,   0, 0);
        vecs[7]  = mk(0, 0, 2'b10, 32'hFFFF_FFFE, 32'h6666_6666, 32'hFFFF_FFFC, 32'h6666_6666, 32'h104, 1, 0);
        vecs[8]  = mk(0, 0, 2'b00, 32'h0,         32'h7777_7777, 32'h0,         32'h7777_7777, 32'h0,   1, 0);
        vecs[9]  = mk(0, 0, 2'b11, 32'h21,        32'h8888_8888, 32'h20,        32'h8888_8888, 32'h4,   1, 0);
        // halt word while stalled / on a redirect must not halt
        vecs[10] = mk(1, 0, 2'b00, 32'h0,         HALT,          32'h20,        32'h8888_8888, 32'h4,   1, 0);
        vecs[11] = mk(0, 0, 2'b01, 32'h20,        HALT,          32'h20,        HALT,          32'h24,  1, 0);
        vecs[12] = mk(0, 0, 2'b00, 32'h0,         HALT,          32'h20,        HALT,          32'h24,  1, 1);
        vecs[13] = mk(0, 1, 2'b10, 32'h40,        32'h1111_1111, 32'h20,        32'h0,         32'h0,   0, 1);
        vecs[14] = mk(1, 0, 2'b00, 32'h0,         HALT,          32'h20,        32'h0,         32'h0,   0, 1);

        drive(mk(0, 0, 2'b00, 32'h0, 32'h1111_1111, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_pp4, vecs[i].e_valid, vecs[i].e_halt);
            @(negedge clk);
        end

        // Asynchronous reset pulse between edges while halted
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        drive(mk(0, 0, 2'b00, 32'h0, 32'hABCD_0001, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk_all("restart", 32'h4, 32'hABCD_0001, 32'h4, 1'b1, 1'b0);

        // Reset mid-stall discards held IF/ID contents
        @(negedge clk);
        drive(mk(1, 0, 2'b00, 32'h0, 32'hABCD_0002, 0, 0, 0, 0, 0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("stall_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
